// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/address widths, opcode field position and
// the instruction-fetch FSM state encoding.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 3;

  // Opcode field lives in ir[8:6]
  localparam int OPC_LSB = 6;
  localparam int OPC_MSB = 8;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  // Fetch FSM encoding, kept as plain vectors so older tools and checkers
  // can compare against the constants directly.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_WAIT  = 2'd1;
  localparam fetch_state_t ST_VALID = 2'd2;

  function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

  // Even-parity bit: makes the total number of ones (word + bit) even.
  function automatic logic even_parity(input logic [INSTR_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ifetch_mem.sv
// Instruction storage: MEM_DEPTH x INSTR_W words, one synchronous write
// port, one asynchronous read port. Synchronous active-high reset clears
// every word. Optional parity column enabled by macro IFETCH_PARITY_EN.
import cpu_pkg::*;

module ifetch_mem #(
  parameter int MEM_DEPTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [PC_W-1:0]    waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [PC_W-1:0]    raddr_i,
`ifdef IFETCH_PARITY_EN
  output logic               rpar_o,
`endif
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [MEM_DEPTH];

  // Word array: reset clears all entries and wins over a pending write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

`ifdef IFETCH_PARITY_EN
  logic par_q [MEM_DEPTH];

  // Parity column: bit is computed from the data at write time
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        par_q[i] <= 1'b0;
      end
    end else if (we_i) begin
      par_q[waddr_i] <= even_parity(wdata_i);
    end
  end

  assign rpar_o = par_q[raddr_i];
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Captures pc_addr, waits FETCH_LAT cycles, then
// issues ir/instr_valid. Any address change or a program-load write to
// the address being fetched restarts the fetch so the issued word is
// always current. Optional parity check enabled by macro IFETCH_PARITY_EN.
//
// Handshake: there is no ready; instr_valid is a level meaning "ir holds
// mem[pc_addr] and is current". It drops on the edge after pc_addr moves
// or the fetched word is rewritten, and rises again once the new fetch
// has waited out its latency.
import cpu_pkg::*;

module instr_fetch #(
  parameter int FETCH_LAT = 2,
  parameter int MEM_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_addr,
  input  logic               ld_en,
  input  logic [PC_W-1:0]    ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  output logic [INSTR_W-1:0] ir,
  output logic               instr_valid,
  output logic               parity_err,
  output fetch_state_t       dbg_state_o
);

  localparam logic [2:0] LAT = 3'(FETCH_LAT);

  fetch_state_t       state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [PC_W-1:0]    cur_addr_q, cur_addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] rd_data;
  logic               restart;
`ifdef IFETCH_PARITY_EN
  logic               rd_par;
  logic               perr_q, perr_d;
`endif

  ifetch_mem #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (ld_en),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .raddr_i (cur_addr_q),
`ifdef IFETCH_PARITY_EN
    .rpar_o  (rd_par),
`endif
    .rdata_o (rd_data)
  );

  // A fetch in flight or already issued is stale if the address moved or
  // its word is being overwritten this cycle.
  assign restart = (pc_addr != cur_addr_q) || (ld_en && (ld_addr == cur_addr_q));

  // Next-state logic for the fetch FSM, latency counter and issue registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_addr_d = cur_addr_q;
    ir_d       = ir_q;
    valid_d    = valid_q;
`ifdef IFETCH_PARITY_EN
    perr_d     = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cur_addr_d = pc_addr;
        cnt_d      = LAT;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (restart) begin
          cur_addr_d = pc_addr;
          cnt_d      = LAT;
        end else if (cnt_q == 3'd1) begin
          // Memory read is asynchronous, so this is the newest data
          ir_d    = rd_data;
          valid_d = 1'b1;
          cnt_d   = 3'd0;
          state_d = ST_VALID;
`ifdef IFETCH_PARITY_EN
          perr_d  = rd_par ^ (^rd_data);
`endif
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_VALID: begin
        if (restart) begin
          cur_addr_d = pc_addr;
          cnt_d      = LAT;
          valid_d    = 1'b0;
          state_d    = ST_WAIT;
`ifdef IFETCH_PARITY_EN
          perr_d     = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      cur_addr_q <= '0;
      ir_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_addr_q <= cur_addr_d;
      ir_q       <= ir_d;
      valid_q    <= valid_d;
    end
  end

`ifdef IFETCH_PARITY_EN
  // Parity error flag, registered alongside instr_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign ir          = ir_q;
  assign instr_valid = valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch (FETCH_LAT=2, MEM_DEPTH=8). Optional parity
// scenario follows macro IFETCH_PARITY_EN.
`timescale 1ns/1ps
import cpu_pkg::*;

module tb_instr_fetch;

  localparam int LAT    = 2;
  localparam int BUDGET = 20;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic [PC_W-1:0]    pc_addr;
  logic               ld_en;
  logic [PC_W-1:0]    ld_addr;
  logic [INSTR_W-1:0] ld_data;
  logic [INSTR_W-1:0] ir;
  logic               instr_valid;
  logic               parity_err;
  fetch_state_t       dbg_state;

  always #5 clk = ~clk;

  instr_fetch #(
    .FETCH_LAT (LAT),
    .MEM_DEPTH (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ir          (ir),
    .instr_valid (instr_valid),
    .parity_err  (parity_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [INSTR_W-1:0] exp_q [$];
  logic [INSTR_W-1:0] model_mem [8];
  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [PC_W-1:0] a, input logic [INSTR_W-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    model_mem[a] = d;
  endtask

  // Steps until instr_valid is seen (or budget runs out); cycles counts
  // edges from the first one after the call, i.e. the capture edge.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      step();
      ld_en = 1'b0;
      cycles++;
    end while (!instr_valid && cycles < BUDGET);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [INSTR_W-1:0] exp;
    int cyc;
    rst = 1'b1;
    pc_addr = '0;
    write_word(3'd3, 16'hFFFF);   // reset must win over this write
    model_mem[3] = '0;
    step();
    step();
    n_tests++;
    if (ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", ir); end
    n_tests++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_tests++;
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    n_tests++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end

    // First fetch: mem[0] loaded on the same edge the FSM leaves IDLE
    rst = 1'b0;
    write_word(3'd0, 16'h0049);
    exp_q.push_back(16'h0049);
    step();
    n_tests++;
    if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL idle_exit: got state %0d want %0d", dbg_state, ST_WAIT); end
    write_word(3'd1, 16'h00C2);   // not the fetched address: no restart
    step();
    ld_en = 1'b0;
    n_tests++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL first_early: got valid %b want 0", instr_valid); end
    wait_valid(cyc);
    exp = exp_q.pop_front();
    n_tests++;
    if (cyc !== 1 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL first_latency: valid %b after %0d extra edges, want 1 after 1", instr_valid, cyc);
    end
    n_tests++;
    if (ir !== exp) begin n_fail++; $display("FAIL first_ir: got %h want %h", ir, exp); end
  endtask

  task automatic test_preload();
    // Writes to other addresses while VALID must leave issue untouched
    for (int a = 2; a < 8; a++) begin
      write_word(a[PC_W-1:0], 16'($urandom_range(0, 16'hFFFF)));
      step();
      ld_en = 1'b0;
      n_tests++;
      if (instr_valid !== 1'b1 || ir !== 16'h0049) begin
        n_fail++; $display("FAIL preload_hold[%0d]: valid %b ir %h want 1 0049", a, instr_valid, ir);
      end
    end
  endtask

  task automatic test_addr_change();
    logic [INSTR_W-1:0] exp;
    int cyc;
    pc_addr = 3'd1;
    exp_q.push_back(model_mem[1]);
    wait_valid(cyc);
    exp = exp_q.pop_front();
    n_tests++;
    if (cyc !== LAT + 1 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL change_latency: valid %b after %0d edges want 1 after %0d", instr_valid, cyc, LAT + 1);
    end
    n_tests++;
    if (ir !== exp || exp !== 16'h00C2) begin n_fail++; $display("FAIL change_ir: got %h want 00c2", ir); end
  endtask

  task automatic test_hazard();
    logic [INSTR_W-1:0] exp;
    int cyc;
    write_word(3'd1, 16'h01D3);
    exp_q.push_back(16'h01D3);
    wait_valid(cyc);
    exp = exp_q.pop_front();
    n_tests++;
    if (cyc !== LAT + 1 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL hazard_latency: valid %b after %0d edges want 1 after %0d", instr_valid, cyc, LAT + 1);
    end
    n_tests++;
    if (ir !== exp) begin n_fail++; $display("FAIL hazard_ir: got %h want %h", ir, exp); end
    write_word(3'd5, 16'h5A5A);
    step();
    ld_en = 1'b0;
    n_tests++;
    if (instr_valid !== 1'b1 || ir !== 16'h01D3) begin
      n_fail++; $display("FAIL other_write: valid %b ir %h want 1 01d3", instr_valid, ir);
    end
  endtask

  task automatic test_back_to_back();
    logic [INSTR_W-1:0] exp;
    int cyc;
    pc_addr = 3'd2;
    step();
    n_tests++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop2: got valid %b want 0", instr_valid); end
    pc_addr = 3'd3;
    step();
    n_tests++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop3: got valid %b want 0", instr_valid); end
    pc_addr = 3'd4;
    exp_q.push_back(model_mem[4]);
    wait_valid(cyc);
    exp = exp_q.pop_front();
    n_tests++;
    if (cyc !== LAT + 1 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_latency: valid %b after %0d edges want 1 after %0d", instr_valid, cyc, LAT + 1);
    end
    n_tests++;
    if (ir !== exp) begin n_fail++; $display("FAIL b2b_ir: got %h want %h", ir, exp); end
  endtask

  task automatic test_parity();
    int cyc;
    logic exp_perr;
`ifdef IFETCH_PARITY_EN
    u_dut.u_mem.par_q[6] = ~(^model_mem[6]);
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    pc_addr = 3'd6;
    exp_q.push_back(model_mem[6]);
    wait_valid(cyc);
    void'(exp_q.pop_front());
    n_tests++;
    if (instr_valid !== 1'b1 || parity_err !== exp_perr) begin
      n_fail++; $display("FAIL parity: valid %b perr %b want 1 %b", instr_valid, parity_err, exp_perr);
    end
  endtask

  task automatic test_coincide();
    logic [INSTR_W-1:0] exp;
    int cyc;
    // Address change and a write to the new address on the same edge
    pc_addr = 3'd7;
    write_word(3'd7, 16'hBEEF);
    exp_q.push_back(16'hBEEF);
    wait_valid(cyc);
    exp = exp_q.pop_front();
    n_tests++;
    if (instr_valid !== 1'b1 || ir !== exp || cyc !== LAT + 1) begin
      n_fail++; $display("FAIL coincide: valid %b ir %h after %0d edges want 1 %h after %0d", instr_valid, ir, cyc, exp, LAT + 1);
    end
  endtask

  task automatic test_random();
    logic [INSTR_W-1:0] exp;
    logic [PC_W-1:0] na;
    int cyc;
    for (int i = 0; i < 8; i++) begin
      na = pc_addr + PC_W'($urandom_range(1, 7));
      pc_addr = na;
      if ($urandom_range(0, 1) == 1) write_word(na, 16'($urandom_range(0, 16'hFFFF)));
      else write_word(na + 3'd1, 16'($urandom_range(0, 16'hFFFF)));
      exp_q.push_back(model_mem[na]);
      wait_valid(cyc);
      exp = exp_q.pop_front();
      n_tests++;
      if (instr_valid !== 1'b1 || ir !== exp || cyc !== LAT + 1 || parity_err !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d]: addr %0d valid %b ir %h perr %b edges %0d want 1 %h 0 %0d",
                 i, na, instr_valid, ir, parity_err, cyc, exp, LAT + 1);
      end
    end
  endtask

  task automatic test_reset_midfetch();
    logic [INSTR_W-1:0] exp;
    int cyc;
    pc_addr = pc_addr + 3'd1;
    step();
    step();
    rst = 1'b1;                   // lands on the edge that would issue
    step();
    n_tests++;
    if (instr_valid !== 1'b0 || ir !== 16'h0000 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL abort: valid %b ir %h state %0d want 0 0000 %0d", instr_valid, ir, dbg_state, ST_IDLE);
    end
    step();
    for (int a = 0; a < 8; a++) model_mem[a] = '0;
    for (int a = 0; a < 8; a++) begin
      pc_addr = a[PC_W-1:0];
      rst = 1'b0;
      exp_q.push_back(model_mem[a]);
      wait_valid(cyc);
      exp = exp_q.pop_front();
      n_tests++;
      if (instr_valid !== 1'b1 || ir !== exp || cyc !== LAT + 1 || parity_err !== 1'b0) begin
        n_fail++; $display("FAIL cleared[%0d]: valid %b ir %h perr %b edges %0d want 1 %h 0 %0d",
                           a, instr_valid, ir, parity_err, cyc, exp, LAT + 1);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; pc_addr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int a = 0; a < 8; a++) model_mem[a] = '0;
    test_reset();
    test_preload();
    test_addr_change();
    test_hazard();
    test_back_to_back();
    test_parity();
    test_coincide();
    test_random();
    test_reset_midfetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter FETCH_LAT, default 2, is the number of wait cycles from address capture to instr_valid (legal range 1..7).
REQ-002 Parameter MEM_DEPTH, default 8, is the number of instruction words and equals 2**PC_W.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 pc_addr  input  3  instruction address from the control unit.
REQ-006 ld_en  input  1  program-load write strobe.
REQ-007 ld_addr  input  3  program-load word address.
REQ-008 ld_data  input  16  program-load word.
REQ-009 ir  output  16  fetched instruction, registered.
REQ-010 instr_valid  output  1  ir holds mem[pc_addr] and is current, registered.
REQ-011 parity_err  output  1  fetched word failed its parity check, registered.

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT and VALID.
REQ-013 IDLE SHALL capture pc_addr into cur_addr, load the latency counter with FETCH_LAT, and go to WAIT on the next cycle.
REQ-014 WAIT SHALL decrement the counter each cycle; at counter==1 it SHALL register ir<=mem[cur_addr], set instr_valid=1 and go to VALID, giving exactly FETCH_LAT+1 cycles from address capture to instr_valid high.
REQ-015 In WAIT, a change of pc_addr versus cur_addr SHALL recapture the address and reload the counter; instr_valid stays 0.
REQ-016 VALID SHALL hold ir and instr_valid stable while pc_addr==cur_addr and no hazard write occurs.
REQ-017 In VALID, pc_addr!=cur_addr SHALL clear instr_valid on the next edge, recapture the address, reload the counter and go to WAIT.
REQ-018 ld_en=1 SHALL write ld_data to mem[ld_addr] on that edge, in every state.
REQ-019 A write with ld_addr==cur_addr in WAIT or VALID SHALL restart the fetch (counter reload, instr_valid=0), so the issued ir always reflects the newest data.
REQ-020 When a write and a pc_addr change coincide, the new pc_addr SHALL be captured, and a write to that new address SHALL be visible to its fetch.
REQ-021 Address arithmetic SHALL be 3-bit unsigned with no wrap handling required beyond natural modulo-8 indexing.
REQ-022 ir SHALL change only on a WAIT->VALID transition or at reset.
REQ-023 instr_valid SHALL never be high in the cycle after any pc_addr change.

Reset
REQ-024 Reset SHALL force state=IDLE, ir=16'h0000, instr_valid=0, parity_err=0, counter=0, cur_addr=0, and clear all memory words and parity bits to 0.
REQ-025 Reset asserted mid-fetch SHALL abort the fetch with no instr_valid pulse; reset SHALL take priority over ld_en.
REQ-026 The FSM SHALL leave IDLE on the first cycle after rst deasserts.

Configuration
REQ-027 With IFETCH_PARITY_EN defined, each word SHALL store an even-parity bit computed at write time, and on issue parity_err SHALL equal the stored bit XOR the reduction-XOR of the word, registered alongside instr_valid.
REQ-028 Without IFETCH_PARITY_EN, no parity storage SHALL exist and parity_err SHALL be constant 0; all other behaviour is identical.

Structure
REQ-029 Shared package cpu_pkg SHALL hold INSTR_W=16, PC_W=3, the opcode field position ir[8:6] and the FSM state encoding typedef.
REQ-030 Storage SHALL be a sub-module ifetch_mem (MEM_DEPTH x 16, one synchronous write port, one asynchronous read port, optional parity column); the FSM and counter stay in instr_fetch.

Verification
REQ-031 Load mem[0]=16'h0049, hold pc_addr=0, release reset -> instr_valid=1 with ir=16'h0049 exactly 3 cycles after IDLE exit (FETCH_LAT=2).
REQ-032 In VALID at addr 0, change pc_addr to 1 (mem[1]=16'h00C2) -> instr_valid=0 on the next edge, then ir=16'h00C2 with instr_valid=1 after FETCH_LAT+1 cycles.
REQ-033 In VALID at addr 1, write ld_addr=1, ld_data=16'h01D3 -> instr_valid drops, then ir=16'h01D3 is reissued; a write to addr 5 instead leaves instr_valid high.
REQ-034 Change pc_addr 2->3->4 on consecutive WAIT cycles -> no instr_valid pulse until FETCH_LAT+1 cycles after the last change, then ir=mem[4].
REQ-035 Assert rst one cycle before the expected instr_valid -> no pulse, ir=0, and all memory reads 0 afterwards.
REQ-036 With IFETCH_PARITY_EN, corrupt the parity bit of mem[6] via backdoor and fetch addr 6 -> parity_err=1 with instr_valid; without the macro, parity_err stays 0.
